regfile_dump_ctrl: RTL and testbench
====================================

Name: regfile_dump_ctrl

Overview:
Debug-unit sequencer that dumps the entire register file over a byte-wide valid/ready stream (UART TX path).
- On a start pulse it walks the register file's debug read port (address out, data in) from register 0 to N_REGS-1.
- Each word is serialised MSB byte first.
- o_busy is held high for the whole dump so the debug unit can hold the pipeline stalled and keep write-back quiescent.

Parameters:
NB_REG, 32, width of each register; must be a multiple of 8.
NB_ADDR, 5, register address width.
N_REGS, 32, number of registers dumped; 1 to 2**NB_ADDR.
NB_BYTE, 8, stream data width; fixed at 8.

Ports:
i_clk  in  1  clock; all logic on posedge.
i_reset  in  1  synchronous, active-high reset.
i_start  in  1  dump request; sampled only in IDLE.
o_dunit_addr  out  NB_ADDR  register-file debug read address.
i_dunit_reg  in  NB_REG  combinational read data for o_dunit_addr.
o_tx_data  out  NB_BYTE  byte to transmit.
o_tx_valid  out  1  o_tx_data is valid.
i_tx_ready  in  1  consumer accepts the byte when valid && ready.
o_busy  out  1  dump in progress (LOAD..DONE); used as pipeline halt.
o_done  out  1  one-cycle pulse at the end of a dump.

Behaviour:
- Reset values: state=IDLE, o_dunit_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, reg/byte counters=0, shift register=0.
- Reset mid-dump aborts immediately. The next cycle shows valid=0 and busy=0. The interrupted byte is not guaranteed delivered.
- FSM states:
  - IDLE: i_start=1 -> LOAD, reg_cnt=0.
  - LOAD: o_dunit_addr=reg_cnt. At the edge, capture i_dunit_reg into the shift reg, byte_cnt=0 -> SEND.
  - SEND: o_tx_valid=1, o_tx_data=shift[NB_REG-1 -: 8]. On valid&&ready: shift left 8, byte_cnt++.
    - On the last byte (byte_cnt==NB_REG/8-1) accepted: if reg_cnt==N_REGS-1 -> DONE, else reg_cnt++ -> LOAD.
  - DONE: o_done=1 for exactly one cycle -> IDLE.
- Latency:
  - i_start sampled at edge k -> LOAD in cycle k+1.
  - First o_tx_valid in cycle k+2.
  - One LOAD bubble cycle (valid=0) between consecutive registers.
- Stream rules:
  - o_tx_data is stable and o_tx_valid is held while valid && !ready.
  - Valid never drops without acceptance, except on reset.
  - Valid has no combinational dependence on ready.
  - Back-to-back acceptance gives one byte per cycle within a register.
- Boundaries:
  - i_start while busy is ignored; no queuing.
  - i_start held high continuously triggers a new dump in the cycle after DONE.
  - N_REGS=1 emits exactly NB_REG/8 bytes.
  - reg_cnt never wraps past N_REGS-1.
  - Counter widths: reg_cnt NB_ADDR+1 bits; byte_cnt clog2(NB_REG/8), minimum 1 bit.
- o_busy=1 in LOAD, SEND and DONE (and HDR/CSUM when enabled).
- Data sampled in LOAD is used as-is; the block assumes the register file is not written while o_busy=1.

Optional Feature:
REGDUMP_FRAMING_EN
- Defined:
  - IDLE goes to HDR first, which sends byte 8'hA5 with the same handshake, then -> LOAD.
  - After the last data byte the FSM goes to CSUM, which sends the XOR of all data bytes, then -> DONE.
  - The checksum accumulator clears on start.
- Undefined: no HDR/CSUM states, no accumulator logic; the stream contains raw data bytes only.

Decomposition:
- Package regdump_pkg:
  - state enum (IDLE, LOAD, SEND, HDR, CSUM, DONE);
  - REGDUMP_HEADER=8'hA5;
  - NB_BYTE=8;
  - function bytes_per_word(NB_REG).
- Natural sub-module: word_byte_serializer. It loads a word, shifts out MSB-first bytes on valid/ready, and flags the last byte. The FSM in regfile_dump_ctrl drives its load and observes last/accept.

Test Plan:
- Preload reg[i]=32'h1000_0000+i, N_REGS=32, ready tied 1, pulse start -> 128 bytes 10 00 00 00, 10 00 00 01, ..., 10 00 00 1F in order; one valid=0 bubble between words; o_done one pulse; o_busy falls the cycle after done.
- Ready toggled randomly (~50%) -> identical byte sequence; o_tx_data unchanged across every stalled cycle; no byte duplicated or dropped.
- Start pulsed three times during a dump -> exactly one dump, 128 bytes, single o_done.
- Reset asserted at byte 37 -> next cycle valid=0, busy=0, o_dunit_addr=0; a fresh start yields a full correct 128-byte dump.
- N_REGS=1, reg[0]=32'hDEADBEEF -> bytes DE AD BE EF, then done.
- With REGDUMP_FRAMING_EN, reg[i]=i -> A5, 128 data bytes, then XOR byte 8'h00; with reg[3]=32'h0000_00FF and all others 0 -> trailer 8'hFF.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared constants, state encodings and helpers for the register-file dump sequencer.
// The framed stream variant is enabled by defining REGDUMP_FRAMING_EN.
package regdump_pkg;

  localparam int NB_BYTE = 8;
  localparam logic [7:0] REGDUMP_HEADER = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LOAD = 3'd1;
  localparam state_t S_SEND = 3'd2;
  localparam state_t S_HDR  = 3'd3;
  localparam state_t S_CSUM = 3'd4;
  localparam state_t S_DONE = 3'd5;

  function automatic int bytes_per_word(input int nb_reg);
    return nb_reg / NB_BYTE;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_serializer.sv
// Word-to-byte serializer: holds one register word and presents it MSB byte first,
// advancing one byte per accepted transfer and flagging the final byte of the word.
module word_byte_serializer #(
  parameter int NB_REG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [NB_REG-1:0] word,
  input  logic              accept,
  output logic [7:0]        tx_byte,
  output logic              last
);
  import regdump_pkg::*;

  localparam int N_BYTES = bytes_per_word(NB_REG);
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_REG-1:0] shift;
  logic [NB_CNT-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shift    <= word;
      byte_cnt <= '0;
    end else if (accept) begin
      shift    <= shift << NB_BYTE;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign tx_byte = shift[NB_REG-1 -: NB_BYTE];
  assign last    = (byte_cnt == NB_CNT'(N_BYTES - 1));

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug-unit sequencer that streams every register, MSB byte first, over a valid/ready link.
// Define REGDUMP_FRAMING_EN to wrap the dump in an A5 header and an XOR checksum trailer.
//
// state | meaning
// IDLE  | waiting for i_start
// HDR   | sending the frame header byte (framing builds only)
// LOAD  | presenting reg_cnt on the debug port, capturing its data
// SEND  | streaming the bytes of the captured word
// CSUM  | sending the XOR of all data bytes (framing builds only)
// DONE  | one-cycle completion pulse
module regfile_dump_ctrl #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_dunit_addr,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);
  import regdump_pkg::*;

  localparam logic [NB_ADDR:0] LAST_REG = (NB_ADDR + 1)'(N_REGS - 1);

  state_t             state;
  logic [NB_ADDR:0]   reg_cnt;
  logic               ser_load;
  logic               ser_accept;
  logic               ser_last;
  logic [NB_BYTE-1:0] ser_byte;

  assign ser_load   = (state == S_LOAD);
  assign ser_accept = (state == S_SEND) && i_tx_ready;

  word_byte_serializer #(.NB_REG(NB_REG)) u_serializer (
    .clk     (i_clk),
    .reset   (i_reset),
    .load    (ser_load),
    .word    (i_dunit_reg),
    .accept  (ser_accept),
    .tx_byte (ser_byte),
    .last    (ser_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      reg_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            reg_cnt <= '0;
`ifdef REGDUMP_FRAMING_EN
            state   <= S_HDR;
`else
            state   <= S_LOAD;
`endif
          end
        end
`ifdef REGDUMP_FRAMING_EN
        S_HDR:  if (i_tx_ready) state <= S_LOAD;
        S_CSUM: if (i_tx_ready) state <= S_DONE;
`endif
        S_LOAD: state <= S_SEND;
        S_SEND: begin
          if (ser_accept && ser_last) begin
            if (reg_cnt == LAST_REG) begin
`ifdef REGDUMP_FRAMING_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end else begin
              reg_cnt <= reg_cnt + 1'b1;
              state   <= S_LOAD;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REGDUMP_FRAMING_EN
  logic [NB_BYTE-1:0] csum;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      csum <= '0;
    end else if (state == S_IDLE && i_start) begin
      csum <= '0;
    end else if (ser_accept) begin
      csum <= csum ^ ser_byte;
    end
  end

  always_comb begin
    o_tx_data = ser_byte;
    if (state == S_HDR) begin
      o_tx_data = REGDUMP_HEADER;
    end else if (state == S_CSUM) begin
      o_tx_data = csum;
    end
  end

  assign o_tx_valid = (state == S_SEND) || (state == S_HDR) || (state == S_CSUM);
`else
  assign o_tx_data  = ser_byte;
  assign o_tx_valid = (state == S_SEND);
`endif

  // Moore outputs only: valid never looks at ready.
  assign o_dunit_addr = reg_cnt[NB_ADDR-1:0];
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench: stimulus queues expected bytes, monitors pop and compare on each handshake.
module tb_regfile_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start1, ready;
  logic [4:0]  addr, addr1;
  logic [31:0] rdata, rdata1;
  logic [7:0]  data, data1;
  logic        valid, valid1, busy, busy1, done, done1;

  logic [31:0] rf [32];
  logic [31:0] rf1_0;

  assign rdata  = rf[addr];
  assign rdata1 = rf1_0;

  regfile_dump_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_dunit_addr(addr), .i_dunit_reg(rdata),
    .o_tx_data(data), .o_tx_valid(valid), .i_tx_ready(ready),
    .o_busy(busy), .o_done(done)
  );

  regfile_dump_ctrl #(.N_REGS(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1),
    .o_dunit_addr(addr1), .i_dunit_reg(rdata1),
    .o_tx_data(data1), .o_tx_valid(valid1), .i_tx_ready(ready),
    .o_busy(busy1), .o_done(done1)
  );

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int ready_mode = 0;
  int accepted = 0, done_cnt = 0, done1_cnt = 0;
  int first_valid_cyc = -1, done_cyc = -1;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(valid), 32'd1);
        check("stall_data_stable", 32'(data), 32'(prev_data));
      end
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL extra_byte: got %h, expected no byte", data);
        end else begin
          check("byte", 32'(data), 32'(exp_q.pop_front()));
        end
        accepted++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (valid1 && ready) begin
        if (exp1_q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL extra_byte_n1: got %h, expected no byte", data1);
        end else begin
          check("byte_n1", 32'(data1), 32'(exp1_q.pop_front()));
        end
      end
      if (done1) done1_cnt++;
    end
  end

  task automatic push_main();
`ifdef REGDUMP_FRAMING_EN
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
`endif
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] bt;
        bt = rf[r][31-8*b -: 8];
        exp_q.push_back(bt);
`ifdef REGDUMP_FRAMING_EN
        x = x ^ bt;
`endif
      end
    end
`ifdef REGDUMP_FRAMING_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start(output int c);
    @(posedge clk); #1;
    start = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > d0) begin
        seen = 1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  int c, d0, a0;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf1_0 = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst = 1'b0;

    // Full dump with ready tied high: latency, bubbles and done timing.
    push_main();
    first_valid_cyc = -1;
    d0 = done_cnt;
    pulse_start(c);
    wait_done(d0, 400, "ready_high");
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single_cycle", 32'(done), 32'd0);
`ifdef REGDUMP_FRAMING_EN
    check("first_valid_latency", 32'(first_valid_cyc - c), 32'd1);
    check("done_latency", 32'(done_cyc - c), 32'd163);
`else
    check("first_valid_latency", 32'(first_valid_cyc - c), 32'd2);
    check("done_latency", 32'(done_cyc - c), 32'd161);
`endif
    check("ready_high_all_bytes", 32'(exp_q.size()), 32'd0);
    check("ready_high_done_count", 32'(done_cnt - d0), 32'd1);

    // Random backpressure.
    ready_mode = 1;
    push_main();
    d0 = done_cnt;
    pulse_start(c);
    wait_done(d0, 2000, "random_ready");
    check("random_ready_all_bytes", 32'(exp_q.size()), 32'd0);

    // Extra start pulses while busy must be ignored.
    push_main();
    d0 = done_cnt;
    pulse_start(c);
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(posedge clk);
      pulse_start(c);
    end
    wait_done(d0, 2000, "start_while_busy");
    repeat (30) @(posedge clk);
    #1;
    check("start_while_busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("start_while_busy_all_bytes", 32'(exp_q.size()), 32'd0);
    check("start_while_busy_idle", 32'(busy), 32'd0);

    // Reset in the middle of a dump, then a clean dump.
    ready_mode = 0;
    @(posedge clk); #1;
    push_main();
    a0 = accepted;
    pulse_start(c);
    for (int i = 0; i < 300; i++) begin
      if (accepted - a0 >= 37) break;
      @(posedge clk); #1;
    end
    check("reached_byte_37", 32'(accepted - a0 >= 37), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    exp_q.delete();
    push_main();
    d0 = done_cnt;
    pulse_start(c);
    wait_done(d0, 400, "after_abort");
    check("after_abort_all_bytes", 32'(exp_q.size()), 32'd0);

    // Single-register instance.
    exp1_q.push_back(8'hDE);
    exp1_q.push_back(8'hAD);
    exp1_q.push_back(8'hBE);
    exp1_q.push_back(8'hEF);
`ifdef REGDUMP_FRAMING_EN
    exp1_q.push_front(8'hA5);
    exp1_q.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    d0 = done1_cnt;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("n1_done_count", 32'(done1_cnt - d0), 32'd1);
    check("n1_all_bytes", 32'(exp1_q.size()), 32'd0);
    check("n1_addr", 32'(addr1), 32'd0);
    check("n1_idle", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
